// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: alternates on contention, otherwise serves the sole requester.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // Priority goes to the port that did not win last time when both ask.
  always_comb begin
    valid = req[0] | req[1];
    if (req == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between two requesters with round-robin grants,
// one transaction in flight, and a watchdog that aborts unanswered accesses.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_read_en,
  input  logic              r0_write_en,
  input  logic [DATA_W-1:0] r0_write_val,
  output logic [DATA_W-1:0] r0_read_val,
  output logic              r0_response,
  output logic              r0_error,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_read_en,
  input  logic              r1_write_en,
  input  logic [DATA_W-1:0] r1_write_val,
  output logic [DATA_W-1:0] r1_read_val,
  output logic              r1_response,
  output logic              r1_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_val,
  input  logic [DATA_W-1:0] mem_read_val,
  input  logic              mem_response,
  output logic              busy,
  output logic              grant_owner
);

  state_t            state_r, state_s;
  logic [1:0]        req_s;
  logic              pick_gnt_s, pick_valid_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wval_s;
  logic              timeout_s;

  logic [31:0]       wd_cnt_r, wd_cnt_s;
  logic              last_grant_r, last_grant_s;
  logic              owner_r, owner_s;
  logic              op_r, op_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wval_r, mem_wval_s;
  logic              mem_re_r, mem_re_s, mem_we_r, mem_we_s;
  logic [DATA_W-1:0] rd_val0_r, rd_val0_s, rd_val1_r, rd_val1_s;
  logic [1:0]        resp_r, resp_s, err_r, err_s;
  logic              busy_r, busy_s;

  assign req_s = {r1_read_en | r1_write_en, r0_read_en | r0_write_en};

  rr_pick2 u_pick (
    .req   (req_s),
    .last  (last_grant_r),
    .gnt   (pick_gnt_s),
    .valid (pick_valid_s)
  );

  // Steer the winning requester's address, data and op towards the latches.
  always_comb begin
    if (pick_gnt_s) begin
      sel_addr_s = r1_addr;
      sel_wval_s = r1_write_val;
      sel_we_s   = r1_write_en;
    end else begin
      sel_addr_s = r0_addr;
      sel_wval_s = r0_write_val;
      sel_we_s   = r0_write_en;
    end
    if (TIMEOUT_CYCLES != 0) begin
      timeout_s = (wd_cnt_r + 32'd1) == 32'(TIMEOUT_CYCLES);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a memory answer in the timeout cycle still counts as completion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (pick_valid_s) state_s = BUSY; else state_s = IDLE;
      BUSY:    if (mem_response || timeout_s) state_s = DONE; else state_s = BUSY;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of every registered output, latch and the watchdog.
  always_comb begin
    mem_addr_s   = mem_addr_r;
    mem_wval_s   = mem_wval_r;
    mem_re_s     = mem_re_r;
    mem_we_s     = mem_we_r;
    rd_val0_s    = rd_val0_r;
    rd_val1_s    = rd_val1_r;
    resp_s       = 2'b00;
    err_s        = 2'b00;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    op_s         = op_r;
    wd_cnt_s     = wd_cnt_r;
    busy_s       = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          mem_addr_s   = sel_addr_s;
          mem_wval_s   = sel_wval_s;
          op_s         = sel_we_s ? OP_WRITE : OP_READ;
          mem_we_s     = sel_we_s;
          mem_re_s     = ~sel_we_s;
          owner_s      = pick_gnt_s;
          last_grant_s = pick_gnt_s;
          wd_cnt_s     = 32'd0;
        end else begin
          wd_cnt_s = wd_cnt_r;
        end
      end
      BUSY: begin
        if (mem_response || timeout_s) begin
          mem_re_s        = 1'b0;
          mem_we_s        = 1'b0;
          resp_s[owner_r] = 1'b1;
          err_s[owner_r]  = ~mem_response;
          if (owner_r) begin
            rd_val1_s = (mem_response && op_r == OP_READ) ? mem_read_val : {DATA_W{1'b0}};
          end else begin
            rd_val0_s = (mem_response && op_r == OP_READ) ? mem_read_val : {DATA_W{1'b0}};
          end
        end else begin
          wd_cnt_s = wd_cnt_r + 32'd1;
        end
      end
      DONE:    wd_cnt_s = wd_cnt_r;
      default: wd_cnt_s = wd_cnt_r;
    endcase
  end

  // Output, latch and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wval_r   <= {DATA_W{1'b0}};
      mem_re_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      rd_val0_r    <= {DATA_W{1'b0}};
      rd_val1_r    <= {DATA_W{1'b0}};
      resp_r       <= 2'b00;
      err_r        <= 2'b00;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      op_r         <= OP_READ;
      wd_cnt_r     <= 32'd0;
      busy_r       <= 1'b0;
    end else begin
      mem_addr_r   <= mem_addr_s;
      mem_wval_r   <= mem_wval_s;
      mem_re_r     <= mem_re_s;
      mem_we_r     <= mem_we_s;
      rd_val0_r    <= rd_val0_s;
      rd_val1_r    <= rd_val1_s;
      resp_r       <= resp_s;
      err_r        <= err_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      op_r         <= op_s;
      wd_cnt_r     <= wd_cnt_s;
      busy_r       <= busy_s;
    end
  end

  assign mem_addr      = mem_addr_r;
  assign mem_write_val = mem_wval_r;
  assign mem_read_en   = mem_re_r;
  assign mem_write_en  = mem_we_r;
  assign r0_read_val   = rd_val0_r;
  assign r1_read_val   = rd_val1_r;
  assign r0_response   = resp_r[0];
  assign r1_response   = resp_r[1];
  assign r0_error      = err_r[0];
  assign r1_error      = err_r[1];
  assign busy          = busy_r;
  assign grant_owner   = owner_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: randomized rounds of requests checked
// against a transaction-level model of grants, memory contents and timing.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr;
  logic          r0_read_en, r0_write_en, r1_read_en, r1_write_en;
  logic [DW-1:0] r0_write_val, r1_write_val, r0_read_val, r1_read_val;
  logic          r0_response, r0_error, r1_response, r1_error;
  logic          mem_read_en, mem_write_en, mem_response, busy, grant_owner;
  logic [DW-1:0] mem_write_val, mem_read_val;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_addr(r0_addr), .r0_read_en(r0_read_en), .r0_write_en(r0_write_en),
    .r0_write_val(r0_write_val), .r0_read_val(r0_read_val),
    .r0_response(r0_response), .r0_error(r0_error),
    .r1_addr(r1_addr), .r1_read_en(r1_read_en), .r1_write_en(r1_write_en),
    .r1_write_val(r1_write_val), .r1_read_val(r1_read_val),
    .r1_response(r1_response), .r1_error(r1_error),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
    .mem_response(mem_response), .busy(busy), .grant_owner(grant_owner)
  );

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   mem_model [logic [31:0]];
  logic          model_last;
  logic [31:0]   prev_rv [2];
  logic [135:0]  outs_s;

  assign outs_s = {r0_read_val, r0_response, r0_error, r1_read_val, r1_response, r1_error,
                   mem_addr, mem_read_en, mem_write_en, mem_write_val, busy, grant_owner};

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    else return a ^ 32'hA5A5_0000;
  endfunction

  task automatic drive_port(input int p, input logic [1:0] en, input logic [31:0] a, input logic [31:0] v);
    if (p == 0) begin
      r0_read_en = en[0]; r0_write_en = en[1]; r0_addr = a; r0_write_val = v;
    end else begin
      r1_read_en = en[0]; r1_write_en = en[1]; r1_addr = a; r1_write_val = v;
    end
  endtask

  // en = {write_en, read_en}; 2'b00 leaves that port idle. lat = cycles of strobe before the memory answers.
  task automatic run_round(input logic [1:0] en_a, input logic [1:0] en_b,
                           input logic [31:0] a_a, input logic [31:0] a_b,
                           input logic [31:0] v_a, input logic [31:0] v_b,
                           input int lat_a, input int lat_b, input bit drop);
    logic [1:0]  en [2];
    logic [31:0] a [2];
    logic [31:0] v [2];
    int          lat [2];
    int          order [2];
    int          nreq, served, t, cnt, first_t, resp_t, grant_t, own, p;
    logic        exp_err, cur_err;
    logic [31:0] exp_rv, cur_rv, other_rv;
    en[0] = en_a; en[1] = en_b; a[0] = a_a; a[1] = a_b;
    v[0] = v_a; v[1] = v_b; lat[0] = lat_a; lat[1] = lat_b;
    order[0] = 0; order[1] = 1;
    if (en[0] != 2'b00 && en[1] != 2'b00) begin
      order[0] = model_last ? 0 : 1; order[1] = 1 - order[0]; nreq = 2;
    end else if (en[0] != 2'b00) begin
      order[0] = 0; nreq = 1;
    end else begin
      order[0] = 1; nreq = 1;
    end
    drive_port(0, en[0], a[0], v[0]);
    drive_port(1, en[1], a[1], v[1]);
    served = 0; t = 0; cnt = 0; grant_t = 1; first_t = 0; resp_t = -100;
    while (served < nreq && t < 60) begin
      @(negedge clk); t++;
      own = order[served];
      checks++;
      if ((r0_error && !r0_response) || (r1_error && !r1_response)) begin
        errors++; $display("FAIL err_without_resp r0_error=%0b r1_error=%0b", r0_error, r1_error);
      end
      if (mem_read_en || mem_write_en) begin
        if (cnt == 0) begin
          first_t = t;
          checks++;
          if (t != grant_t) begin
            errors++; $display("FAIL grant_time got cycle %0d want %0d", t, grant_t);
          end
          checks++;
          if (grant_owner !== own[0] || busy !== 1'b1) begin
            errors++; $display("FAIL owner got %0b busy %0b want %0d busy 1", grant_owner, busy, own);
          end
          checks++;
          if (mem_write_en !== en[own][1] || mem_read_en !== ~en[own][1]) begin
            errors++; $display("FAIL op got we=%0b re=%0b want we=%0b", mem_write_en, mem_read_en, en[own][1]);
          end
          if (drop) drive_port(own, 2'b00, $urandom, $urandom);
        end
        checks++;
        if (mem_addr !== a[own] || (en[own][1] && mem_write_val !== v[own]) || cnt > lat[own] || cnt >= TO) begin
          errors++;
          $display("FAIL bus_hold addr %h want %h wval %h want %h strobe_cycle %0d lat %0d",
                   mem_addr, a[own], mem_write_val, v[own], cnt, lat[own]);
        end
        if (cnt == lat[own]) begin
          mem_response = 1'b1;
          mem_read_val = en[own][1] ? $urandom : mem_peek(a[own]);
          resp_t = t;
        end else begin
          mem_response = 1'b0;
          mem_read_val = $urandom;
        end
        cnt++;
      end else begin
        mem_response = 1'b0;
      end
      if (r0_response || r1_response) begin
        p = r1_response ? 1 : 0;
        exp_err = (lat[own] >= TO);
        exp_rv = (exp_err || en[own][1]) ? 32'd0 : mem_peek(a[own]);
        cur_err = own[0] ? r1_error : r0_error;
        cur_rv = own[0] ? r1_read_val : r0_read_val;
        other_rv = own[0] ? r0_read_val : r1_read_val;
        checks++;
        if (p != own || (r0_response && r1_response) || (own[0] ? r0_error : r1_error)) begin
          errors++; $display("FAIL resp_port got r0=%0b r1=%0b want port %0d", r0_response, r1_response, own);
        end
        checks++;
        if (t != (exp_err ? first_t + TO : resp_t + 1)) begin
          errors++; $display("FAIL resp_time got cycle %0d want %0d", t, exp_err ? first_t + TO : resp_t + 1);
        end
        checks++;
        if (cur_err !== exp_err) begin
          errors++; $display("FAIL error_flag got %0b want %0b", cur_err, exp_err);
        end
        checks++;
        if (cur_rv !== exp_rv) begin
          errors++; $display("FAIL read_val got %h want %h", cur_rv, exp_rv);
        end
        checks++;
        if (other_rv !== prev_rv[1-own]) begin
          errors++; $display("FAIL other_read_val got %h want %h", other_rv, prev_rv[1-own]);
        end
        if (!drop) drive_port(own, 2'b00, a[own], v[own]);
        if (en[own][1] && !exp_err) mem_model[a[own]] = v[own];
        prev_rv[own] = exp_rv;
        model_last = own[0];
        served++; cnt = 0; grant_t = t + 2;
      end
    end
    checks++;
    if (served != nreq) begin
      errors++; $display("FAIL round_timeout served %0d want %0d", served, nreq);
    end
    @(negedge clk);
    mem_response = 1'b0;
    checks++;
    if (busy !== 1'b0 || r0_response || r1_response || mem_read_en || mem_write_en) begin
      errors++; $display("FAIL idle_after busy=%0b re=%0b we=%0b", busy, mem_read_en, mem_write_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_port(0, 2'b00, 32'd0, 32'd0);
    drive_port(1, 2'b00, 32'd0, 32'd0);
    mem_response = 1'b0; mem_read_val = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs_s !== 136'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs_s);
    end
    reset = 1'b0;
    model_last = 1'b1; prev_rv[0] = 32'd0; prev_rv[1] = 32'd0;
    @(negedge clk);
    checks++;
    if (outs_s !== 136'd0) begin
      errors++; $display("FAIL idle_outputs got %h want 0", outs_s);
    end
  endtask

  task automatic test_write();
    run_round(2'b10, 2'b00, 32'd3, 32'd0, 32'd8, 32'd0, 2, 0, 1'b0);
  endtask

  task automatic test_read();
    mem_model[32'd5] = 32'd6;
    run_round(2'b00, 2'b01, 32'd0, 32'd5, 32'd0, 32'd0, 0, 1, 1'b0);
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++)
      run_round(2'($urandom_range(1, 2)), 2'($urandom_range(1, 2)), 32'($urandom_range(0, 7)),
                32'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
  endtask

  task automatic test_timeout();
    run_round(2'b01, 2'b00, 32'd7, 32'd0, 32'd0, 32'd0, 99, 0, 1'b0);
    run_round(2'b00, 2'b10, 32'd0, 32'd2, 32'd0, 32'h55, 0, TO, 1'b0);
    run_round(2'b01, 2'b01, 32'd2, 32'd7, 32'd0, 32'd0, TO - 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_port(1, 2'b01, 32'h40, 32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (mem_read_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy re=%0b busy=%0b want 1 1", mem_read_en, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs_s !== 136'd0) begin
      errors++; $display("FAIL async_reset got %h want 0", outs_s);
    end
    drive_port(1, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_response = 1'b1; mem_read_val = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_response = 1'b0;
    checks++;
    if (outs_s !== 136'd0) begin
      errors++; $display("FAIL late_response got %h want 0", outs_s);
    end
    model_last = 1'b1; prev_rv[0] = 32'd0; prev_rv[1] = 32'd0;
    run_round(2'b01, 2'b10, 32'd1, 32'd4, 32'd0, 32'h77, 1, 0, 1'b0);
  endtask

  task automatic test_both_en_stray();
    run_round(2'b11, 2'b00, 32'd6, 32'd0, 32'd9, 32'd0, 1, 0, 1'b0);
    mem_response = 1'b1; mem_read_val = $urandom;
    @(negedge clk);
    mem_response = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (outs_s !== {prev_rv[0], 2'b00, prev_rv[1], 2'b00, 32'd6, 2'b00, 32'd9, 1'b0, 1'b0}) begin
        errors++; $display("FAIL stray_response got %h", outs_s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [1:0] e0, e1;
    for (int i = 0; i < 24; i++) begin
      e0 = 2'($urandom_range(0, 3));
      e1 = 2'($urandom_range(0, 3));
      if (e0 == 2'b00 && e1 == 2'b00) e0 = 2'b01;
      run_round(e0, e1, 32'($urandom_range(0, 7)), 32'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_both_en_stray();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
